// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the clkref-slotted SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int unsigned SLOT_LEN  = 8;
   localparam int unsigned CNT_W     = $clog2(SLOT_LEN);
   localparam int unsigned NUM_PORTS = 3;

   localparam int unsigned PORT_VIDEO = 0;
   localparam int unsigned PORT_CPU   = 1;
   localparam int unsigned PORT_DMA   = 2;

   // Which requester owns the current slot; NONE lets the controller refresh.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_P0   = 2'd1,
      GNT_P1   = 2'd2,
      GNT_P2   = 2'd3
   } grant_e;

endpackage

// File: rtl/sdram_slot_timer.sv
// clkref rising-edge detect plus a saturating position counter within the slot.
// slot_cnt_o reads 0 in the clk after the edge is seen, matching the
// controller's own q==0, and parks at SLOT_LEN-1 while clkref stays quiet.
module sdram_slot_timer
   import sdram_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clkref_i,
   output logic             slot_start_o,
   output logic [CNT_W-1:0] slot_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_LEN - 1);

   logic             clkref_q;
   logic [CNT_W-1:0] slot_cnt_q;
   logic [CNT_W-1:0] slot_cnt_d;

   assign slot_start_o = clkref_i & ~clkref_q;
   assign slot_cnt_o   = slot_cnt_q;

   // Next slot position: restart on an edge, otherwise count up and saturate.
   always_comb begin
      slot_cnt_d = slot_cnt_q;
      if (slot_start_o) begin
         slot_cnt_d = '0;
      end else if (slot_cnt_q != CNT_MAX) begin
         slot_cnt_d = slot_cnt_q + CNT_W'(1);
      end
   end

   // Edge-detect register and slot position register.
   always_ff @(posedge clk) begin
      if (reset) begin
         clkref_q   <= 1'b0;
         slot_cnt_q <= CNT_MAX;
      end else begin
         clkref_q   <= clkref_i;
         slot_cnt_q <= slot_cnt_d;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of the single-port SDRAM controller.
// One requester is granted per clkref slot; its command is latched at slot
// start and held on the controller interface for the whole slot.
//
// Handshake: reqN is a level request whose addr/we/din/ds fields stay stable
// until ackN. ackN is a one-clk pulse at slot_cnt RD_CYCLE+1; the requester
// drops reqN in the clk after ackN. A reqN still high at the next slot start
// counts as a fresh request. Reset or an early clkref edge abandons the
// in-flight access without an ack.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned RD_CYCLE    = 6,
   parameter int unsigned REFRESH_MAX = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clkref,
   input  logic        req0,
   input  logic        req1,
   input  logic        req2,
   input  logic [23:0] addr0,
   input  logic [23:0] addr1,
   input  logic [23:0] addr2,
   input  logic        we0,
   input  logic        we1,
   input  logic        we2,
   input  logic [15:0] din0,
   input  logic [15:0] din1,
   input  logic [15:0] din2,
   input  logic [1:0]  ds0,
   input  logic [1:0]  ds1,
   input  logic [1:0]  ds2,
   output logic        ack0,
   output logic        ack1,
   output logic        ack2,
   output logic [15:0] dout0,
   output logic [15:0] dout1,
   output logic [15:0] dout2,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_ds,
   output logic        mem_oe,
   output logic        mem_we,
   input  logic [15:0] mem_dout,
   output grant_e      dbg_grant_o
);

   localparam int unsigned       BUSY_W   = $clog2(REFRESH_MAX + 1);
   localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(REFRESH_MAX);
   localparam logic [CNT_W-1:0]  RD_CNT   = CNT_W'(RD_CYCLE);

   logic             slot_start;
   logic [CNT_W-1:0] slot_cnt;

   grant_e            grant_q, grant_d;
   grant_e            rr_last_q, rr_last_d;
   logic [BUSY_W-1:0] busy_q, busy_d;

   logic [23:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_din_q, mem_din_d;
   logic [1:0]  mem_ds_q, mem_ds_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_oe_q, mem_oe_d;

   logic [NUM_PORTS-1:0] ack_q;
   logic [15:0]          dout_q [NUM_PORTS];
   logic                 done_q;
   logic                 complete;

   sdram_slot_timer u_slot_timer (
      .clk          (clk),
      .reset        (reset),
      .clkref_i     (clkref),
      .slot_start_o (slot_start),
      .slot_cnt_o   (slot_cnt)
   );

   // Grant decision plus refresh-guard and round-robin bookkeeping at slot start.
   always_comb begin
      grant_d   = grant_q;
      rr_last_d = rr_last_q;
      busy_d    = busy_q;
      if (slot_start) begin
         if (busy_q == BUSY_MAX) begin
            grant_d = GNT_NONE;
         end else if (req0) begin
            grant_d = GNT_P0;
         end else if (req1 && req2) begin
            grant_d = (rr_last_q == GNT_P1) ? GNT_P2 : GNT_P1;
         end else if (req1) begin
            grant_d = GNT_P1;
         end else if (req2) begin
            grant_d = GNT_P2;
         end else begin
            grant_d = GNT_NONE;
         end

         if ((grant_d == GNT_P1) || (grant_d == GNT_P2)) begin
            rr_last_d = grant_d;
         end

         if (grant_d == GNT_NONE) begin
            busy_d = '0;
         end else if (busy_q != BUSY_MAX) begin
            busy_d = busy_q + BUSY_W'(1);
         end
      end
   end

   // Controller command for the coming slot; an idle slot only drops oe/we.
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_ds_d   = mem_ds_q;
      mem_we_d   = mem_we_q;
      mem_oe_d   = mem_oe_q;
      if (slot_start) begin
         case (grant_d)
            GNT_P0: begin
               mem_addr_d = addr0;
               mem_din_d  = din0;
               mem_ds_d   = ds0;
               mem_we_d   = we0;
               mem_oe_d   = ~we0;
            end
            GNT_P1: begin
               mem_addr_d = addr1;
               mem_din_d  = din1;
               mem_ds_d   = ds1;
               mem_we_d   = we1;
               mem_oe_d   = ~we1;
            end
            GNT_P2: begin
               mem_addr_d = addr2;
               mem_din_d  = din2;
               mem_ds_d   = ds2;
               mem_we_d   = we2;
               mem_oe_d   = ~we2;
            end
            default: begin
               mem_we_d = 1'b0;
               mem_oe_d = 1'b0;
            end
         endcase
      end
   end

   // Grant state, arbitration bookkeeping and held controller command.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q    <= GNT_NONE;
         rr_last_q  <= GNT_P2;
         busy_q     <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_ds_q   <= '0;
         mem_we_q   <= 1'b0;
         mem_oe_q   <= 1'b0;
      end else begin
         grant_q    <= grant_d;
         rr_last_q  <= rr_last_d;
         busy_q     <= busy_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_ds_q   <= mem_ds_d;
         mem_we_q   <= mem_we_d;
         mem_oe_q   <= mem_oe_d;
      end
   end

   // done_q keeps a saturated slot_cnt from completing the same slot twice.
   assign complete = (slot_cnt == RD_CNT) && (grant_q != GNT_NONE) && !done_q;

   // Completion: capture read data and pulse the owner's ack for one clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q  <= '0;
         dout_q <= '{default: '0};
         done_q <= 1'b0;
      end else begin
         ack_q <= '0;
         if (complete) begin
            case (grant_q)
               GNT_P0: begin
                  ack_q[PORT_VIDEO] <= 1'b1;
                  if (!mem_we_q) dout_q[PORT_VIDEO] <= mem_dout;
               end
               GNT_P1: begin
                  ack_q[PORT_CPU] <= 1'b1;
                  if (!mem_we_q) dout_q[PORT_CPU] <= mem_dout;
               end
               GNT_P2: begin
                  ack_q[PORT_DMA] <= 1'b1;
                  if (!mem_we_q) dout_q[PORT_DMA] <= mem_dout;
               end
               default: ;
            endcase
         end
         if (slot_start) begin
            done_q <= 1'b0;
         end else if (complete) begin
            done_q <= 1'b1;
         end
      end
   end

   assign ack0        = ack_q[PORT_VIDEO];
   assign ack1        = ack_q[PORT_CPU];
   assign ack2        = ack_q[PORT_DMA];
   assign dout0       = dout_q[PORT_VIDEO];
   assign dout1       = dout_q[PORT_CPU];
   assign dout2       = dout_q[PORT_DMA];
   assign mem_addr    = mem_addr_q;
   assign mem_din     = mem_din_q;
   assign mem_ds      = mem_ds_q;
   assign mem_we      = mem_we_q;
   assign mem_oe      = mem_oe_q;
   assign dbg_grant_o = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: the bench owns clkref, runs a slot-level
// reference arbiter, and checks the held command, ack timing and read data.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
   import sdram_arb_pkg::*;

   localparam int RD_CYCLE    = 6;
   localparam int REFRESH_MAX = 8;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic clkref = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        req_r  [3];
   logic [23:0] addr_r [3];
   logic        we_r   [3];
   logic [15:0] din_r  [3];
   logic [1:0]  ds_r   [3];
   logic        ack0, ack1, ack2;
   logic [15:0] dout0, dout1, dout2;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_ds;
   logic        mem_oe, mem_we;
   logic [15:0] mem_dout;
   grant_e      dbg_grant;

   function automatic logic [15:0] mem_model(input logic [23:0] a);
      if (a == 24'h001234) return 16'hBEEF;
      return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h3C5A;
   endfunction

   assign mem_dout = mem_model(mem_addr);

   sdram_port_arbiter #(.RD_CYCLE(RD_CYCLE), .REFRESH_MAX(REFRESH_MAX)) dut (
      .clk(clk), .reset(reset), .clkref(clkref),
      .req0(req_r[0]), .req1(req_r[1]), .req2(req_r[2]),
      .addr0(addr_r[0]), .addr1(addr_r[1]), .addr2(addr_r[2]),
      .we0(we_r[0]), .we1(we_r[1]), .we2(we_r[2]),
      .din0(din_r[0]), .din1(din_r[1]), .din2(din_r[2]),
      .ds0(ds_r[0]), .ds1(ds_r[1]), .ds2(ds_r[2]),
      .ack0(ack0), .ack1(ack1), .ack2(ack2),
      .dout0(dout0), .dout1(dout1), .dout2(dout2),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_ds(mem_ds),
      .mem_oe(mem_oe), .mem_we(mem_we), .mem_dout(mem_dout),
      .dbg_grant_o(dbg_grant)
   );

   // ---------------- reference model / scoreboard state ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   int          pos, ph, cur_g, pend_g, b_busy, b_rr;
   bit          start_pending, run, log_en;
   logic [43:0] cur_cmd, pend_cmd;
   logic [15:0] exp_dout [3];
   logic [17:0] exp_q[$];
   logic [1:0]  glog[$];
   bit          stream [3];
   bit          stop_r [3];
   bit          drop_next [3];
   bit          raise_next [3];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      pos = 7; cur_g = -1; pend_g = -1; start_pending = 0;
      cur_cmd = '0; pend_cmd = '0;
      b_busy = 0; b_rr = 2;
      exp_q.delete();
      for (int p = 0; p < 3; p++) begin
         exp_dout[p] = '0; drop_next[p] = 0; raise_next[p] = 0;
      end
   endtask

   task automatic new_fields(input int p);
      addr_r[p] = 24'($urandom);
      we_r[p]   = 1'($urandom_range(0, 1));
      din_r[p]  = 16'($urandom);
      ds_r[p]   = 2'($urandom_range(0, 3));
   endtask

   task automatic set_req(input int p, input logic [23:0] a, input logic w,
                          input logic [15:0] d, input logic [1:0] s);
      addr_r[p] = a; we_r[p] = w; din_r[p] = d; ds_r[p] = s; req_r[p] = 1'b1;
   endtask

   // Slot-level reference arbitration, run at the negedge that raises clkref.
   task automatic predict();
      int g;
      g = -1;
      if (b_busy == REFRESH_MAX)           g = -1;
      else if (req_r[0])                   g = 0;
      else if (req_r[1] && req_r[2])       g = (b_rr == 1) ? 2 : 1;
      else if (req_r[1])                   g = 1;
      else if (req_r[2])                   g = 2;
      if (g < 0) begin
         b_busy   = 0;
         pend_cmd = {2'b00, cur_cmd[41:0]};
      end else begin
         if (b_busy < REFRESH_MAX) b_busy++;
         if (g != 0) b_rr = g;
         pend_cmd = {~we_r[g], we_r[g], addr_r[g], din_r[g], ds_r[g]};
         if (!we_r[g]) exp_dout[g] = mem_model(addr_r[g]);
         exp_q.push_back({2'(g), exp_dout[g]});
      end
      pend_g = g;
      start_pending = 1;
   endtask

   // One clk: sample at negedge, check, then update requesters and clkref.
   task automatic step();
      logic [2:0]  ack_v, exp_ack;
      logic [15:0] dsel;
      int          ap;
      bit          fresh7, new_slot;
      @(negedge clk);
      fresh7 = 0; new_slot = 0;
      if (reset) begin
         model_reset();
      end else if (start_pending) begin
         pos = 0; start_pending = 0; cur_g = pend_g; cur_cmd = pend_cmd; new_slot = 1;
      end else if (pos < 7) begin
         pos++;
         fresh7 = (pos == RD_CYCLE + 1);
      end

      check_eq("cmd", {mem_oe, mem_we, mem_addr, mem_din, mem_ds}, cur_cmd);
      ack_v   = {ack2, ack1, ack0};
      exp_ack = (fresh7 && cur_g >= 0) ? 3'(1 << cur_g) : 3'b000;
      check_eq("ack", ack_v, exp_ack);
      check_eq("grant", dbg_grant, (cur_g < 0) ? 0 : cur_g + 1);
      if (ack_v != 3'b000) begin
         check_eq("sb_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            ap   = ack_v[0] ? 0 : (ack_v[1] ? 1 : 2);
            dsel = (ap == 0) ? dout0 : ((ap == 1) ? dout1 : dout2);
            check_eq("ack_data", {2'(ap), dsel}, exp_q.pop_front());
         end
      end
      if (new_slot && log_en) glog.push_back(dbg_grant);

      for (int p = 0; p < 3; p++) begin
         if (ack_v[p]) begin
            if (stream[p] && !stop_r[p]) drop_next[p] = 1;
            else begin
               req_r[p] = 1'b0; stream[p] = 0; stop_r[p] = 0;
            end
         end else if (drop_next[p]) begin
            req_r[p] = 1'b0; drop_next[p] = 0; raise_next[p] = 1;
         end else if (raise_next[p]) begin
            raise_next[p] = 0; new_fields(p); req_r[p] = 1'b1;
         end
      end

      if (run) begin
         ph = (ph + 1) % 8;
         clkref = (ph < 4);
         if (ph == 0 && !reset) predict();
      end else begin
         clkref = 1'b0;
         ph = 7;
      end
   endtask

   task automatic wait_pos(input int k);
      for (int i = 0; i < 64 && pos != k; i++) step();
      check_eq("wait_pos", pos, k);
   endtask

   task automatic wait_slots(input int n);
      for (int i = 0; i < 400 && glog.size() < n; i++) step();
      check_eq("slot_count", glog.size(), n);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int p = 0; p < 3; p++) begin
         req_r[p] = 0; addr_r[p] = '0; we_r[p] = 0; din_r[p] = '0; ds_r[p] = '0;
         stream[p] = 0; stop_r[p] = 0;
      end
      ph = 7; run = 0; log_en = 0;
      model_reset();

      // Reset state.
      reset = 1'b1;
      repeat (3) step();
      check_eq("rst_dout", {dout0, dout1, dout2}, 48'h0);
      reset = 1'b0;
      step();

      // CPU read at 0x001234.
      set_req(1, 24'h001234, 1'b0, 16'h0000, 2'b11);
      run = 1;
      repeat (24) step();
      check_eq("dout1_beef", dout1, 16'hBEEF);

      // DMA write; dout2 must stay at its reset value.
      set_req(2, 24'($urandom), 1'b1, 16'h5A5A, 2'b01);
      repeat (24) step();
      check_eq("dout2_kept", dout2, 16'h0000);

      // All three streaming: eight p0 slots, one forced idle, then p0 again.
      wait_pos(1);
      for (int p = 0; p < 3; p++) begin
         stream[p] = 1; new_fields(p); req_r[p] = 1'b1;
      end
      glog.delete(); log_en = 1;
      wait_slots(10);
      for (int i = 0; i < 10; i++)
         check_eq($sformatf("starve_slot%0d", i), glog[i], (i == 8) ? GNT_NONE : GNT_P0);

      // Video stops for good: CPU and DMA alternate.
      stop_r[0] = 1;
      glog.delete();
      wait_slots(4);
      check_eq("rr_0", glog[0], GNT_P1);
      check_eq("rr_1", glog[1], GNT_P2);
      check_eq("rr_2", glog[2], GNT_P1);
      check_eq("rr_3", glog[3], GNT_P2);

      // clkref held low mid-slot for 22 clks, then resumes.
      wait_pos(2);
      run = 0;
      repeat (22) step();
      run = 1;
      glog.delete();
      wait_slots(2);
      check_eq("resume_0", glog[0], GNT_P1);
      check_eq("resume_1", glog[1], GNT_P2);
      log_en = 0;
      stop_r[1] = 1; stop_r[2] = 1;
      repeat (40) step();

      // Reset during a read at slot_cnt 3; request stays pending across reset.
      set_req(1, 24'($urandom), 1'b0, 16'h0000, 2'b11);
      for (int i = 0; i < 64 && !(pos == 3 && cur_g == 1); i++) step();
      check_eq("reset_point", {pos[3:0], 4'(cur_g)}, {4'd3, 4'd1});
      reset = 1'b1; run = 0;
      step();
      check_eq("rst_oe", mem_oe, 1'b0);
      step();
      reset = 1'b0;
      step();
      run = 1;
      repeat (24) step();

      // Drain and final state.
      repeat (16) step();
      check_eq("sb_drain", exp_q.size(), 0);
      check_eq("final_dout0", dout0, exp_dout[0]);
      check_eq("final_dout1", dout1, exp_dout[1]);
      check_eq("final_dout2", dout2, exp_dout[2]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single-port SDRAM controller between three requesters: port 0 is video/refresh-critical, ports 1 and 2 are CPU and loader/DMA. Memory time is divided into fixed 8-clk slots aligned to the rising edge of clkref, the same alignment the SDRAM controller uses. One requester is granted per slot. The block holds that requester's command stable on the controller interface for the whole slot, then returns read data and an ack. A starvation guard forces an idle slot so the controller can auto-refresh.

Parameters:
- RD_CYCLE, 6: slot_cnt value at which mem_dout is captured and ack is issued. Must be 1..7.
- REFRESH_MAX, 8: maximum number of consecutive granted slots before one idle slot is forced. Must be ≥1.

Ports:
- clk  in  1  SDRAM clock, same clock as the controller.
- reset  in  1  synchronous, active-high.
- clkref  in  1  slot reference. A rising edge starts a slot.
- req0/req1/req2  in  1 each  level request. Held high with fields stable until the matching ack.
- addr0/addr1/addr2  in  24 each  word address.
- we0/we1/we2  in  1 each  1 = write, 0 = read.
- din0/din1/din2  in  16 each  write data.
- ds0/ds1/ds2  in  2 each  byte strobes {hi, lo}.
- ack0/ack1/ack2  out  1 each  one-clk pulse when the access completes.
- dout0/dout1/dout2  out  16 each  read data. Updated only on a read ack for that port.
- mem_addr  out  24  to controller addr.
- mem_din  out  16  to controller din.
- mem_ds  out  2  to controller ds.
- mem_oe  out  1  to controller oe.
- mem_we  out  1  to controller we.
- mem_dout  in  16  from controller dout.

Behaviour:
- Clocking and reset:
  - clk clock, reset synchronous active-high.
  - On reset: mem_oe=0, mem_we=0, mem_addr=0, mem_din=0, mem_ds=0; ack*=0; dout*=0; grant=NONE; slot_cnt=7; busy_cnt=0; rr_last=port2 (so port1 wins the first tie).
- Slot timing:
  - clkref_d is clkref registered once; slot_start = clkref & ~clkref_d. This matches the controller's q-reset timing, so the arbiter's slot_cnt 0 coincides with the controller's q==0.
  - slot_cnt: set to 0 on slot_start, otherwise increments and saturates at 7.
  - With no clkref edge, no new grant is made and the outputs keep their idle/held values.
- Grant, evaluated only on slot_start:
  - If busy_cnt == REFRESH_MAX: grant=NONE (forced idle).
  - Else if req0: grant port 0.
  - Else if req1 and req2: grant the port not equal to rr_last.
  - Else grant whichever of req1/req2 is high.
  - Else grant=NONE.
  - rr_last updates only when port 1 or port 2 is granted.
- Command drive, registered on slot_start:
  - Granted port p: mem_addr=addr_p, mem_din=din_p, mem_ds=ds_p, mem_we=we_p, mem_oe=~we_p.
  - NONE: mem_oe=0, mem_we=0, so the controller issues AUTO_REFRESH. addr/din/ds hold their previous values.
  - Values are held unchanged until the next slot_start. Requester inputs changing mid-slot have no effect.
- busy_cnt: on slot_start, increments (saturating at REFRESH_MAX) when a port is granted; cleared when grant=NONE.
- Completion, when slot_cnt==RD_CYCLE and grant!=NONE:
  - On that clk edge: for a read, dout_p <= mem_dout; ack_p <= 1.
  - ack_p drops on the next clk. Exactly one ack per granted slot.
  - mem_oe and mem_we stay asserted until the next slot_start.
- Requester rule: req_p must drop in the clk after ack_p. Any req_p still high at the next slot_start is treated as a new request.
- Reset mid-slot: the in-flight access is abandoned with no ack. The controller sees oe=we=0 from the next clk. The requester must re-request after reset.
- Short slot: a slot_start before slot_cnt reaches RD_CYCLE aborts the current slot with no ack. The new grant is taken normally.

Decomposition:
- Package sdram_arb_pkg:
  - SLOT_LEN=8.
  - Port index constants PORT_VIDEO=0, PORT_CPU=1, PORT_DMA=2.
  - Grant enum {NONE, P0, P1, P2}, 2 bits.
- One sub-module, sdram_slot_timer: clkref edge detect plus the saturating slot_cnt. It outputs slot_start and slot_cnt and is reused by other clkref-slotted blocks.

Test Plan:
- req1 read at addr 0x00_1234, mem_dout model returns 0xBEEF during the slot -> mem_oe=1, mem_addr=0x001234 from slot_cnt 0 through 7; ack1 is a single pulse at slot_cnt RD_CYCLE+1; dout1=0xBEEF.
- req0, req1 and req2 held high continuously, with each req dropped one clk after its ack and re-raised one clk later -> grants p0,p0,...; after p0 drops permanently, grants p1,p2,p1,p2 alternate.
- All three reqs held across 10 slots with REFRESH_MAX=8 -> slots 1–8 granted, slot 9 has mem_oe=mem_we=0 with no ack, slot 10 granted.
- req2 write of din=0x5A5A, ds=2'b01 -> mem_we=1, mem_oe=0, mem_ds=01, mem_din=0x5A5A held for 8 clks; ack2 pulses; dout2 unchanged.
- Reset asserted at slot_cnt 3 of a read -> next clk mem_oe=0, no ack ever; first slot after release grants a pending req normally.
- clkref held low for 20 clks mid-operation -> after slot_cnt saturates at 7, no new grants and ack* stay 0; normal operation resumes on the next edge.
